// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the RV32 pipeline hazard-control slice.
//   hz_state_t : hazard controller states (run, load-use stall, memory freeze)
//   REG_X0     : index of the hard-wired zero register
// No ports (package only).
// -----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_FREEZE     = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use compare between the instruction in ID and a load in
// EX. A destination of x0 never produces a hazard since x0 is never written.
// Ports:
//   id_ex_mem_read  in   EX instruction is a load
//   id_ex_rd        in   destination register of the EX instruction
//   if_id_rs1/rs2   in   source registers of the ID instruction
//   if_id_uses_rs1/rs2 in  ID instruction actually reads that source
//   load_use        out  ID must wait one cycle for the load data
// -----------------------------------------------------------------------------
module load_use_detect
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic                  if_id_uses_rs1,
   input  logic                  if_id_uses_rs2,
   output logic                  load_use
);

   logic rd_nonzero_s;
   logic rs1_hit_s;
   logic rs2_hit_s;

   assign rd_nonzero_s = (id_ex_rd != REG_ADDR_W'(REG_X0));
   assign rs1_hit_s    = if_id_uses_rs1 & (if_id_rs1 == id_ex_rd);
   assign rs2_hit_s    = if_id_uses_rs2 & (if_id_rs2 == id_ex_rd);
   assign load_use     = id_ex_mem_read & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
// ID-stage hazard controller for the 5-stage RV32 pipeline. Inserts exactly one
// bubble on a load-use hazard, flushes IF/ID on a taken branch and freezes the
// whole pipe while data memory is busy. A freeze remembers the state it
// interrupted and resumes it when the memory wait ends.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_id_rs1/rs2, if_id_uses_rs1/rs2   ID instruction sources
//   id_ex_rd, id_ex_mem_read  EX instruction destination / is-load
//   branch_taken              EX resolved a taken branch/jump
//   dmem_stall                MEM waiting on data memory
//   pc_write, if_id_write, id_ex_write, ex_mem_write   pipeline enables
//   id_ex_bubble              zero ID/EX control fields
//   if_id_flush               clear IF/ID to NOP
//   stall_cycles, flush_count saturating performance counters
// Configuration macro: HAZARD_PERF_CNT_EN enables the counters; without it
// the counter ports are tied to zero and no counter flops exist.
// Outputs are combinational so a load-use stall takes effect in the very cycle
// it is detected.
// -----------------------------------------------------------------------------
module hazard_detection_unit
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic                  if_id_uses_rs1,
   input  logic                  if_id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_mem_read,
   input  logic                  branch_taken,
   input  logic                  dmem_stall,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  id_ex_bubble,
   output logic                  if_id_flush,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   logic      load_use_s;
   hz_state_t state_r;
   hz_state_t saved_r;
   hz_state_t state_nxt_s;
   hz_state_t saved_nxt_s;
   hz_state_t eff_state_s;
   logic      stall_inc_s;
   logic      flush_inc_s;

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rd       (id_ex_rd),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_uses_rs1 (if_id_uses_rs1),
      .if_id_uses_rs2 (if_id_uses_rs2),
      .load_use       (load_use_s)
   );

   // Effective state: once the freeze releases, behave as the interrupted state.
   always_comb begin
      eff_state_s = state_r;
      if (state_r == HZ_FREEZE) begin
         eff_state_s = saved_r;
      end else begin
         eff_state_s = state_r;
      end
   end

   // Next-state and output decode in priority order rst > dmem > branch > load-use.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      state_nxt_s  = HZ_RUN;
      saved_nxt_s  = saved_r;
      stall_inc_s  = 1'b0;
      flush_inc_s  = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         state_nxt_s  = HZ_RUN;
         saved_nxt_s  = HZ_RUN;
      end else if (dmem_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         state_nxt_s  = HZ_FREEZE;
         // Only capture on entry; a continuing freeze keeps the original state.
         if (state_r != HZ_FREEZE) begin
            saved_nxt_s = state_r;
         end else begin
            saved_nxt_s = saved_r;
         end
      end else if (branch_taken) begin
         // The hazarding ID instruction is squashed, so load-use is moot here.
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         state_nxt_s  = HZ_RUN;
         flush_inc_s  = 1'b1;
      end else begin
         case (eff_state_s)
            HZ_RUN: begin
               if (load_use_s) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  state_nxt_s  = HZ_LOAD_STALL;
                  stall_inc_s  = 1'b1;
               end else begin
                  state_nxt_s  = HZ_RUN;
               end
            end
            // The bubble is already in EX; the hazard resolves via forwarding.
            HZ_LOAD_STALL: state_nxt_s = HZ_RUN;
            default:       state_nxt_s = HZ_RUN;
         endcase
      end
   end

   // State and saved-state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= HZ_RUN;
         saved_r <= HZ_RUN;
      end else begin
         state_r <= state_nxt_s;
         saved_r <= saved_nxt_s;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end
         if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
         end
      end
   end

   assign stall_cycles = stall_cnt_r;
   assign flush_count  = flush_cnt_r;
`else
   logic unused_cnt_s;

   assign unused_cnt_s = stall_inc_s | flush_inc_s;
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Directed bench for hazard_detection_unit. A history-based model (did the last
// non-frozen, non-reset cycle issue a load-use stall?) predicts the controls
// and counters every cycle; directed steps also pin literal expectations.
// Counters are expected live only when HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_detection_unit;

   localparam int RW   = 5;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [RW-1:0] if_id_rs1;
   logic [RW-1:0] if_id_rs2;
   logic          if_id_uses_rs1;
   logic          if_id_uses_rs2;
   logic [RW-1:0] id_ex_rd;
   logic          id_ex_mem_read;
   logic          branch_taken;
   logic          dmem_stall;
   logic          pc_write;
   logic          if_id_write;
   logic          id_ex_write;
   logic          ex_mem_write;
   logic          id_ex_bubble;
   logic          if_id_flush;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   // model history
   bit m_last_stalled = 1'b0;
   int m_sc = 0;
   int m_fc = 0;

   hazard_detection_unit #(
      .REG_ADDR_W (RW),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_uses_rs1 (if_id_uses_rs1),
      .if_id_uses_rs2 (if_id_uses_rs2),
      .id_ex_rd       (id_ex_rd),
      .id_ex_mem_read (id_ex_mem_read),
      .branch_taken   (branch_taken),
      .dmem_stall     (dmem_stall),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .id_ex_write    (id_ex_write),
      .ex_mem_write   (ex_mem_write),
      .id_ex_bubble   (id_ex_bubble),
      .if_id_flush    (if_id_flush),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] ctl_vec();
      return {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, if_id_flush};
   endfunction

   // Model: controls {pc,ifid,idex,exmem,bubble,flush} from the rules, checked every cycle.
   always @(negedge clk) begin
      logic [5:0] e;
      bit lu;
      lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
           ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
            (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));
      if (rst)                          e = 6'b000011;
      else if (dmem_stall)              e = 6'b000000;
      else if (branch_taken)            e = 6'b111111;
      else if (lu && !m_last_stalled)   e = 6'b001110;
      else                              e = 6'b111100;
      check("model_ctl", 32'(ctl_vec()), 32'(e));
      check("model_stall_cnt", 32'(stall_cycles), PERF ? m_sc : 0);
      check("model_flush_cnt", 32'(flush_count), PERF ? m_fc : 0);
      // advance history as of the coming clock edge
      if (rst) begin
         m_last_stalled = 1'b0;
         m_sc = 0;
         m_fc = 0;
      end else if (dmem_stall) begin
         m_last_stalled = m_last_stalled;
      end else if (branch_taken) begin
         m_last_stalled = 1'b0;
         if (m_fc < CMAX) m_fc++;
      end else if (lu && !m_last_stalled) begin
         m_last_stalled = 1'b1;
         if (m_sc < CMAX) m_sc++;
      end else begin
         m_last_stalled = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic mr, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic dm);
      id_ex_mem_read = mr;
      id_ex_rd       = rd;
      if_id_rs1      = rs1;
      if_id_rs2      = rs2;
      if_id_uses_rs1 = u1;
      if_id_uses_rs2 = u2;
      branch_taken   = br;
      dmem_stall     = dm;
   endtask

   // Hand-computed expectation for the current cycle, then advance one clock.
   task automatic expect_all(input string nm, input logic [5:0] e, input int sc, input int fc);
      @(negedge clk);
      check({nm, "_ctl"}, 32'(ctl_vec()), 32'(e));
      check({nm, "_sc"}, 32'(stall_cycles), PERF ? sc : 0);
      check({nm, "_fc"}, 32'(flush_count), PERF ? fc : 0);
      step();
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_all("reset", 6'b000011, 0, 0);
      rst = 1'b0;
      expect_all("idle", 6'b111100, 0, 0);

      // 1: load-use on rs1 -> one bubble cycle
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("t1_stall", 6'b001110, 0, 0);
      expect_all("t1_load_stall", 6'b111100, 1, 0);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("t1_after", 6'b111100, 1, 0);

      // 2: rd = x0 never stalls
      set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("t2_x0", 6'b111100, 1, 0);

      // 3: branch overrides load-use (after a fresh reset)
      rst = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("t3_rst", 6'b000011, 1, 0);
      rst = 1'b0;
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      expect_all("t3_branch", 6'b111111, 0, 0);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("t3_cnt", 6'b111100, 0, 1);

      // 4: freeze entered from LOAD_STALL, resumes it, then RUN
      set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("t4_stall", 6'b001110, 0, 1);
      dmem_stall = 1'b1;
      expect_all("t4_frz0", 6'b000000, 1, 1);
      expect_all("t4_frz1", 6'b000000, 1, 1);
      expect_all("t4_frz2", 6'b000000, 1, 1);
      dmem_stall = 1'b0;
      expect_all("t4_resume_ls", 6'b111100, 1, 1);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("t4_run", 6'b111100, 1, 1);

      // 5: reset during LOAD_STALL -> back to RUN, counters cleared
      set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("t5_stall", 6'b001110, 1, 1);
      rst = 1'b1;
      expect_all("t5_rst", 6'b000011, 2, 1);
      rst = 1'b0;
      expect_all("t5_run_again", 6'b001110, 0, 0);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("t5_after", 6'b111100, 1, 0);

      // 6: only sources actually read can hazard
      set_in(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_all("t6_rs2_stall", 6'b001110, 1, 0);
      set_in(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("t6_ls", 6'b111100, 2, 0);
      expect_all("t6_unused", 6'b111100, 2, 0);
      set_in(1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_all("t6_rs1_only", 6'b111100, 2, 0);

      // saturation of flush counter
      for (int i = 0; i < 20; i++) begin
         set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         step();
      end
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("sat", 6'b111100, 2, CMAX);

      // patterned mix checked by the model
      for (int i = 0; i < 60; i++) begin
         set_in((i % 3) != 0, 5'(i % 4), 5'((i * 3) % 4), 5'((i * 5) % 4),
                i[0], i[1], (i % 7) == 0, (i % 5) == 0);
         step();
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
